// File: rtl/ltc2311_pkg.sv
// Shared constants for the LTC2311 conversion path: reader timing,
// the derived minimum conversion period and the default sample width.
package ltc2311_pkg;

  // Reader transaction timing in clk cycles.
  localparam int CONVERT_CYCLES = 3;
  localparam int READ_CYCLES    = 16;
  // Slack so the reader is idle again before the next request arrives.
  localparam int MARGIN_CYCLES  = 5;

  // Shortest period that still lets one full reader transaction finish.
  localparam int ADC_MIN_PERIOD = CONVERT_CYCLES + READ_CYCLES + MARGIN_CYCLES;

  // Native LTC2311 result width (two's complement).
  localparam int ADC_DATA_W = 16;

  // Limit a requested averaging exponent to the largest supported one.
  function automatic int clamp_log2(input int req, input int max_log2);
    return (req > max_log2) ? max_log2 : req;
  endfunction

endpackage

// File: rtl/ltc2311_sample_timer.sv
// Conversion pacing timer: counts 0..P-1 while enabled, with
// P = max(sample_period, MIN_PERIOD), and flags every count-0 cycle as a trigger.
module ltc2311_sample_timer
  import ltc2311_pkg::*;
#(
  parameter int PERIOD_W   = 16,
  parameter int MIN_PERIOD = ADC_MIN_PERIOD
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] sample_period,
  output logic                trigger
);

  logic [PERIOD_W-1:0] period_eff;
  logic [PERIOD_W-1:0] count_reg;
  logic [PERIOD_W-1:0] count_next;
  logic                armed_reg;
  logic                run;

  // The timer only runs once the first clock after reset has passed, so a
  // held-high enable cannot produce a trigger while reset is asserted.
  assign run     = enable & armed_reg;
  assign trigger = run & (count_reg == '0);

  // Clamp the programmed period up to the shortest legal one.
  always_comb begin
    period_eff = sample_period;
    if (sample_period < PERIOD_W'(MIN_PERIOD)) begin
      period_eff = PERIOD_W'(MIN_PERIOD);
    end
  end

  // Next count: park at zero when stopped, wrap at P-1 (>= also covers a period shrinking mid-count).
  always_comb begin
    count_next = count_reg + PERIOD_W'(1);
    if (!run) begin
      count_next = '0;
    end else if (count_reg >= period_eff - PERIOD_W'(1)) begin
      count_next = '0;
    end
  end

  // Period counter and post-reset arming flag.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      count_reg <= '0;
      armed_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      armed_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/ltc2311_oversampler.sv
// LTC2311 oversampler: paces reader conversions, averages 2^L samples per
// window and presents the result on a valid/ready stream with sticky flags.
module ltc2311_oversampler
  import ltc2311_pkg::*;
#(
  parameter int DATA_W       = ADC_DATA_W,
  parameter int AVG_LOG2_MAX = 4,
  parameter int PERIOD_W     = 16,
  parameter int MIN_PERIOD   = ADC_MIN_PERIOD
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] sample_period,
  input  logic [2:0]          avg_log2,
  output logic                adc_read,
  input  logic                adc_busy,
  input  logic [DATA_W-1:0]   adc_data,
  input  logic                adc_data_valid,
  output logic [DATA_W-1:0]   m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                overrun,
  output logic                missed_trigger,
  input  logic                clear_flags
);

  localparam int ACC_W = DATA_W + AVG_LOG2_MAX;
  localparam int CNT_W = AVG_LOG2_MAX + 1;
  localparam int L_W   = 3;

  logic                    trigger;
  logic                    outstanding_reg;
  logic                    sample_accept;
  logic [L_W-1:0]          l_req;
  logic [L_W-1:0]          l_cur;
  logic [L_W-1:0]          l_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [CNT_W-1:0]        cnt_inc;
  logic [CNT_W-1:0]        win_len;
  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] acc_sum;
  logic [DATA_W-1:0]       shifted [AVG_LOG2_MAX+1];
  logic [DATA_W-1:0]       result;
  logic                    window_done;
  logic [DATA_W-1:0]       m_data_reg;
  logic                    m_valid_reg;
  logic                    overrun_reg;
  logic                    missed_reg;
  logic                    overrun_set;
  logic                    missed_set;

  ltc2311_sample_timer #(
    .PERIOD_W   (PERIOD_W),
    .MIN_PERIOD (MIN_PERIOD)
  ) u_timer (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .sample_period (sample_period),
    .trigger       (trigger)
  );

  // A trigger becomes a request only when no conversion is pending and the reader is idle.
  assign adc_read   = trigger & ~outstanding_reg & ~adc_busy;
  assign missed_set = trigger & (outstanding_reg | adc_busy);

  // Only results of our own requests count, and only while running.
  assign sample_accept = adc_data_valid & outstanding_reg & enable;

  // The exponent is sampled on the first sample of a window and held for the rest.
  assign l_req = L_W'(clamp_log2(int'(avg_log2), AVG_LOG2_MAX));
  assign l_cur = (cnt_reg == '0) ? l_req : l_reg;

  assign sample_ext  = {{AVG_LOG2_MAX{adc_data[DATA_W-1]}}, adc_data};
  assign acc_sum     = acc_reg + sample_ext;
  assign cnt_inc     = cnt_reg + CNT_W'(1);
  assign win_len     = CNT_W'(1) << l_cur;
  assign window_done = sample_accept & (cnt_inc == win_len);
  assign overrun_set = window_done & m_valid_reg & ~m_ready;

  // One arithmetic-shift tap per supported exponent (floor division by 2^gi).
  generate
    for (genvar gi = 0; gi <= AVG_LOG2_MAX; gi++) begin : g_shift
      assign shifted[gi] = DATA_W'(acc_sum >>> gi);
    end
  endgenerate

  // Select the tap matching this window's exponent.
  always_comb begin
    result = shifted[0];
    for (int i = 1; i <= AVG_LOG2_MAX; i++) begin
      if (l_cur == L_W'(i)) begin
        result = shifted[i];
      end
    end
  end

  // Track the single conversion in flight; it retires even when stopped.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      outstanding_reg <= 1'b0;
    end else if (adc_read) begin
      outstanding_reg <= 1'b1;
    end else if (adc_data_valid) begin
      outstanding_reg <= 1'b0;
    end
  end

  // Window accumulator; a completed window restarts in the same cycle, stopping drops the partial sum.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      acc_reg <= '0;
      cnt_reg <= '0;
      l_reg   <= '0;
    end else if (!enable) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (sample_accept) begin
      l_reg <= l_cur;
      if (window_done) begin
        acc_reg <= '0;
        cnt_reg <= '0;
      end else begin
        acc_reg <= acc_sum;
        cnt_reg <= cnt_inc;
      end
    end
  end

  // Output register: a new result always loads, otherwise a handshake drains it.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      m_data_reg  <= '0;
      m_valid_reg <= 1'b0;
    end else if (window_done) begin
      m_data_reg  <= result;
      m_valid_reg <= 1'b1;
    end else if (m_valid_reg && m_ready) begin
      m_valid_reg <= 1'b0;
    end
  end

  // Sticky flags; a set event beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      overrun_reg <= 1'b0;
      missed_reg  <= 1'b0;
    end else begin
      if (overrun_set) begin
        overrun_reg <= 1'b1;
      end else if (clear_flags) begin
        overrun_reg <= 1'b0;
      end
      if (missed_set) begin
        missed_reg <= 1'b1;
      end else if (clear_flags) begin
        missed_reg <= 1'b0;
      end
    end
  end

  assign m_data         = m_data_reg;
  assign m_valid        = m_valid_reg;
  assign overrun        = overrun_reg;
  assign missed_trigger = missed_reg;

endmodule

// File: doc/ltc2311_oversampler.md
Name: ltc2311_oversampler

Overview:
Downstream companion to the LTC2311 serial reader. It paces conversions by pulsing the reader's read input at a programmable sample period. It collects each 16-bit result on the reader's one-cycle data_valid pulse and averages 2^avg_log2 consecutive samples. The averaged sample is presented on a valid/ready stream to the DSP/capture path, with sticky error flags.

Parameters:
DATA_W, 16, ADC sample width (two's complement)
AVG_LOG2_MAX, 4, largest averaging exponent; accumulator width DATA_W+AVG_LOG2_MAX
PERIOD_W, 16, width of sample_period
MIN_PERIOD, 24, smallest legal sample period in clk cycles (one reader transaction plus margin)

Ports:
clk  in  1  system clock, same clock as the reader
reset_n  in  1  reset; asynchronous, active-high (asserted when reset_n=1)
enable  in  1  run/stop
sample_period  in  PERIOD_W  clk cycles between conversion requests
avg_log2  in  3  averaging exponent; values above AVG_LOG2_MAX are clamped
adc_read  out  1  one-cycle request pulse to the reader
adc_busy  in  1  reader busy
adc_data  in  DATA_W  reader data_out
adc_data_valid  in  1  reader one-cycle data_valid
m_data  out  DATA_W  averaged sample
m_valid  out  1  output holds an unconsumed sample
m_ready  in  1  consumer accepts
overrun  out  1  sticky: an unconsumed output was overwritten
missed_trigger  out  1  sticky: a trigger was dropped because the ADC was not free
clear_flags  in  1  clears both sticky flags

Behaviour:
- Reset values: adc_read=0, m_data=0, m_valid=0, overrun=0, missed_trigger=0. Timer, accumulator, sample counter and outstanding flag are all cleared.
- Effective period: P = max(sample_period, MIN_PERIOD).
- Timer: while enable=1, counts 0..P-1 and wraps to 0. Each cycle at count 0 is a trigger. The first trigger occurs on the first enabled cycle after enable rises.
- Trigger with outstanding=0 and adc_busy=0: adc_read=1 for exactly that cycle, and outstanding is set.
- Trigger with outstanding=1 or adc_busy=1: no pulse is issued and missed_trigger is set.
- outstanding clears on the cycle adc_data_valid=1. adc_data_valid seen while outstanding=0 is ignored.
- Window start: avg_log2 is latched, clamped to AVG_LOG2_MAX, at the start of every averaging window. A change mid-window takes effect at the next window.
- Accumulation: adc_data is sign-extended to DATA_W+AVG_LOG2_MAX and added. The sample counter increments.
- Window completion: when the counter reaches 2^L (L = latched exponent), result = acc >>> L (arithmetic shift, truncation toward -inf). The result loads m_data one cycle after the last valid. The accumulator and counter clear in the same cycle; there are no dead samples between windows.
- L=0: every sample passes straight through, one cycle of latency from adc_data_valid to m_valid.
- Output handshake: m_valid stays high until m_valid&m_ready, and m_data is stable while m_valid=1.
- Overrun: if a new result loads while m_valid=1 and m_ready=0, m_data is overwritten and overrun is set.
- Consume and load in the same cycle: the load wins (m_valid stays 1, new data) and overrun is not set.
- clear_flags: clears both sticky flags. If a flag set event occurs in the same cycle as clear_flags, set wins.
- enable falling: timer stops and no further adc_read is issued. The partial accumulator and counter are cleared. An outstanding conversion still completes and clears outstanding, but its sample is discarded. The output register, m_valid and the flags are kept.
- Reset mid-operation: all state returns to reset values immediately. No adc_read glitch is produced.

Decomposition:
- Package ltc2311_pkg holds: CONVERT_CYCLES=3, READ_CYCLES=16, MIN_PERIOD derivation, and the DATA_W default.
- One sub-module, ltc2311_sample_timer: the period counter, clamp and trigger generation.
- Accumulation, handshake and flags stay in the top level.

Test Plan:
- Stream, no averaging: avg_log2=0, sample_period=30, bench reader model returns 0x1234 then 0x8000. Expect adc_read pulses exactly 30 cycles apart; m_data=0x1234 then 0x8000 (negative), each one cycle after valid.
- Averaging: avg_log2=2, samples 0x0004, 0x0008, 0xFFFC, 0x0000 → m_data=0x0002. Then samples -1,-1,-1,-2 → m_data=0xFFFE (floor of -5/4).
- Period clamp: sample_period=5 → adc_read spacing is 24 cycles and missed_trigger stays 0. With the reader model held busy 40 cycles, missed_trigger=1; then clear_flags → 0.
- Backpressure: avg_log2=0, m_ready=0, two results arrive → m_data holds the second result, overrun=1. Load coinciding with m_ready=1 → overrun stays 0.
- Enable drop: disable after 2 of 4 samples with a conversion in flight → no further adc_read, the in-flight sample is discarded. Re-enable → the first output averages 4 fresh samples.
- Async reset: assert reset_n=1 mid-window for 1 cycle → all outputs return to 0 within the cycle, and resumed operation produces a clean full window.
